// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage SimpleRisc pipeline: RAW interlock,
// taken-branch squash, multi-cycle div/mod hold in EX, and saturating stall/flush counters.
//
// state  | meaning
// S_RUN  | EX not occupied by a multi-cycle op; watching for div/mod entering EX
// S_HOLD | div/mod occupying EX; cnt counts remaining held cycles down to 1
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      of_instruction,
  input  logic [31:0]      ex_instruction,
  input  logic [31:0]      ma_instruction,
  input  logic [31:0]      rw_instruction,
  input  logic             ex_is_wb,
  input  logic             ma_is_wb,
  input  logic             rw_is_wb,
  input  logic             isBranchTaken,
  output logic             if_stall,
  output logic             of_stall,
  output logic             of_bubble,
  output logic             ex_bubble,
  output logic             ex_hold,
  output logic             ma_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;
  localparam logic [3:0] REG_RA  = 4'd15;

  localparam bit         HOLD_EN  = (DIV_CYCLES > 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {S_RUN, S_HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       hold_raw;
  logic       hold_active;
  logic       hazard;
  logic       ex_is_div;

  // True when the given instruction (sitting in OF) reads register r.
  function automatic logic reads_reg(input logic [31:0] instr, input logic [3:0] r);
    logic [4:0] op;
    logic       imm;
    logic       use_rs1, use_rs2, use_rd, use_ra;
    op      = instr[31:27];
    imm     = instr[26];
    use_rs1 = (op <= 5'd7) || ((op >= 5'd10) && (op <= 5'd12)) ||
              (op == OP_LD) || (op == OP_ST);
    use_rs2 = !imm && (op <= 5'd12);
    use_rd  = (op == OP_ST);
    use_ra  = (op == OP_RET);
    return (use_rs1 && (instr[21:18] == r)) ||
           (use_rs2 && (instr[17:14] == r)) ||
           (use_rd  && (instr[25:22] == r)) ||
           (use_ra  && (r == REG_RA));
  endfunction

  // call writes the return address into r15 rather than its rd field.
  function automatic logic [3:0] dest_reg(input logic [31:0] instr);
    return (instr[31:27] == OP_CALL) ? REG_RA : instr[25:22];
  endfunction

  always_comb begin
    hazard = 1'b0;
    if (ex_is_wb && reads_reg(of_instruction, dest_reg(ex_instruction))) hazard = 1'b1;
    if (ma_is_wb && reads_reg(of_instruction, dest_reg(ma_instruction))) hazard = 1'b1;
    if (rw_is_wb && reads_reg(of_instruction, dest_reg(rw_instruction))) hazard = 1'b1;
  end

  assign ex_is_div = (ex_instruction[31:27] == OP_DIV) || (ex_instruction[31:27] == OP_MOD);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_raw  = 1'b0;
    case (state)
      S_RUN: begin
        if (ex_is_div && HOLD_EN) begin
          hold_raw  = 1'b1;
          cnt_nxt   = DIV_LOAD;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_nxt  = cnt - 4'd1;
        hold_raw = (cnt > 4'd1);
        if (cnt <= 4'd1) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // A div still parked in EX while reset is low must not raise a hold from RUN.
  assign hold_active = hold_raw && reset;

  always_comb begin
    if_stall  = 1'b0;
    of_stall  = 1'b0;
    of_bubble = 1'b0;
    ex_bubble = 1'b0;
    ex_hold   = 1'b0;
    ma_bubble = 1'b0;
    if (isBranchTaken) begin
      of_bubble = 1'b1;
      ex_bubble = 1'b1;
    end else if (hold_active) begin
      if_stall  = 1'b1;
      of_stall  = 1'b1;
      ex_hold   = 1'b1;
      ma_bubble = 1'b1;
    end else if (hazard) begin
      if_stall  = 1'b1;
      of_stall  = 1'b1;
      ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RUN;
      cnt          <= 4'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (if_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_ONE;
      if (isBranchTaken && (flush_count != '1)) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus a DIV_CYCLES=1,
// CNT_W=4 instance sharing the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] of_i, ex_i, ma_i, rw_i;
  logic        ex_wb, ma_wb, rw_wb, br;

  logic        if_stall, of_stall, of_bubble, ex_bubble, ex_hold, ma_bubble;
  logic [15:0] stall_cycles, flush_count;
  logic        if_stall2, of_stall2, of_bubble2, ex_bubble2, ex_hold2, ma_bubble2;
  logic [3:0]  stall_cycles2, flush_count2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .of_instruction(of_i), .ex_instruction(ex_i), .ma_instruction(ma_i), .rw_instruction(rw_i),
    .ex_is_wb(ex_wb), .ma_is_wb(ma_wb), .rw_is_wb(rw_wb), .isBranchTaken(br),
    .if_stall(if_stall), .of_stall(of_stall), .of_bubble(of_bubble), .ex_bubble(ex_bubble),
    .ex_hold(ex_hold), .ma_bubble(ma_bubble),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.DIV_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .of_instruction(of_i), .ex_instruction(ex_i), .ma_instruction(ma_i), .rw_instruction(rw_i),
    .ex_is_wb(ex_wb), .ma_is_wb(ma_wb), .rw_is_wb(rw_wb), .isBranchTaken(br),
    .if_stall(if_stall2), .of_stall(of_stall2), .of_bubble(of_bubble2), .ex_bubble(ex_bubble2),
    .ex_hold(ex_hold2), .ma_bubble(ma_bubble2),
    .stall_cycles(stall_cycles2), .flush_count(flush_count2)
  );

  // {if_stall, of_stall, of_bubble, ex_bubble, ex_hold, ma_bubble}
  logic [5:0] ctl, ctl2;
  assign ctl  = {if_stall, of_stall, of_bubble, ex_bubble, ex_hold, ma_bubble};
  assign ctl2 = {if_stall2, of_stall2, of_bubble2, ex_bubble2, ex_hold2, ma_bubble2};

  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b110100;
  localparam logic [5:0] C_HOLD  = 6'b110011;
  localparam logic [5:0] C_FLUSH = 6'b001100;

  localparam logic [31:0] NOP = 32'h6800_0000;

  function automatic logic [31:0] enc(input int op, input int imm, input int rd,
                                      input int rs1, input int rs2);
    logic [31:0] w;
    w = {op[4:0], imm[0], rd[3:0], rs1[3:0], rs2[3:0], 14'd0};
    return w;
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_pipe(input logic [31:0] o, input logic [31:0] e, input logic [31:0] m,
                          input logic [31:0] r, input logic ew, input logic mw,
                          input logic rwv, input logic b);
    of_i = o; ex_i = e; ma_i = m; rw_i = r;
    ex_wb = ew; ma_wb = mw; rw_wb = rwv; br = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] add_r3, sub_r4, mov_r4, call_i, ret_i, st_r3, div_r5;

  initial begin
    add_r3 = enc(0, 0, 3, 1, 2);
    sub_r4 = enc(1, 0, 4, 3, 5);
    mov_r4 = enc(9, 1, 4, 0, 0) | 32'd5;
    call_i = enc(19, 1, 0, 0, 0);
    ret_i  = enc(20, 0, 0, 0, 0);
    st_r3  = enc(15, 1, 3, 1, 0);
    div_r5 = enc(3, 0, 5, 1, 2);

    reset = 1'b0;
    set_pipe(NOP, NOP, NOP, NOP, 0, 0, 0, 0);
    chk_val("reset_ctl", ctl, C_IDLE);
    chk_val("reset_stall_cnt", stall_cycles, 0);
    chk_val("reset_flush_cnt", flush_count, 0);
    tick();
    reset = 1'b1;
    tick();

    // writer drains EX -> MA -> RW while the reader waits in OF
    set_pipe(sub_r4, add_r3, NOP, NOP, 1, 0, 0, 0);
    chk_val("haz_ex", ctl, C_STALL);
    tick();
    set_pipe(sub_r4, NOP, add_r3, NOP, 0, 1, 0, 0);
    chk_val("haz_ma", ctl, C_STALL);
    tick();
    set_pipe(sub_r4, NOP, NOP, add_r3, 0, 0, 1, 0);
    chk_val("haz_rw", ctl, C_STALL);
    tick();
    set_pipe(sub_r4, NOP, NOP, NOP, 0, 0, 0, 0);
    chk_val("haz_drained", ctl, C_IDLE);
    chk_val("haz_stall_cnt", stall_cycles, 3);

    set_pipe(mov_r4, add_r3, NOP, NOP, 1, 0, 0, 0);
    chk_val("mov_imm_no_haz", ctl, C_IDLE);
    tick();
    set_pipe(ret_i, NOP, call_i, NOP, 0, 1, 0, 0);
    chk_val("ret_vs_call_ma", ctl, C_STALL);
    tick();
    set_pipe(st_r3, NOP, NOP, add_r3, 0, 0, 1, 0);
    chk_val("st_rd_vs_rw", ctl, C_STALL);
    tick();
    set_pipe(sub_r4, add_r3, NOP, NOP, 0, 0, 0, 0);
    chk_val("no_wb_no_haz", ctl, C_IDLE);
    tick();
    chk_val("stall_cnt_5", stall_cycles, 5);
    chk_val("stall_cnt1_5", stall_cycles2, 5);

    // div occupies EX for 4 cycles: held in the first 3
    for (int k = 0; k < 3; k++) begin
      set_pipe(NOP, div_r5, NOP, NOP, 1, 0, 0, 0);
      chk_val($sformatf("div_hold_%0d", k), ctl, C_HOLD);
      chk_val($sformatf("div1_nohold_%0d", k), ctl2, C_IDLE);
      tick();
    end
    set_pipe(NOP, div_r5, NOP, NOP, 1, 0, 0, 0);
    chk_val("div_last", ctl, C_IDLE);
    tick();
    // a second div reaching EX in RUN retriggers
    set_pipe(NOP, div_r5, NOP, NOP, 1, 0, 0, 0);
    chk_val("div_retrigger", ctl, C_HOLD);
    tick();
    chk_val("stall_cnt_9", stall_cycles, 9);
    chk_val("div_in_hold", ctl, C_HOLD);

    // asynchronous reset in the middle of HOLD, between edges
    #2 reset = 1'b0;
    #1;
    chk_val("arst_ctl", ctl, C_IDLE);
    chk_val("arst_stall_cnt", stall_cycles, 0);
    chk_val("arst_flush_cnt", flush_count, 0);
    set_pipe(NOP, NOP, NOP, NOP, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    set_pipe(NOP, NOP, NOP, NOP, 0, 0, 0, 0);
    chk_val("post_rst_idle", ctl, C_IDLE);
    tick();
    chk_val("post_rst_idle2", ctl, C_IDLE);

    // flush outranks a pending hazard
    set_pipe(sub_r4, add_r3, NOP, NOP, 1, 0, 0, 1);
    chk_val("flush_over_haz", ctl, C_FLUSH);
    tick();
    set_pipe(NOP, NOP, NOP, NOP, 0, 0, 0, 0);
    chk_val("flush_cnt_1", flush_count, 1);
    chk_val("flush_cnt1_1", flush_count2, 1);
    chk_val("flush_no_stall", stall_cycles, 0);

    // saturation on the 4-bit counter instance
    set_pipe(sub_r4, add_r3, NOP, NOP, 1, 0, 0, 0);
    for (int k = 0; k < 20; k++) tick();
    chk_val("stall_cnt_20", stall_cycles, 20);
    chk_val("stall_cnt1_sat", stall_cycles2, 15);
    tick();
    tick();
    chk_val("stall_cnt_22", stall_cycles, 22);
    chk_val("stall_cnt1_sat_hold", stall_cycles2, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
